// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder (one fulladder cell + carry FF), LSB first.
// Optional overflow flag output ovf when SERIAL_ADDER_OVERFLOW_EN is defined.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    fulladder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .s    (fa_s)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // carry_q is the carry into the MSB on this final step
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=4), optional SERIAL_ADDER_OVERFLOW_EN.

module tb_serial_adder_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic         mon_en = 1'b0;
    logic         rst_at_edge = 1'b0;
    logic [W:0]   prev_res = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf     (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        int sa, sb, r;
        sa = (av >= 8) ? int'(av) - 16 : int'(av);
        sb = (bv >= 8) ? int'(bv) - 16 : int'(bv);
        r  = sa + sb + int'(ci);
        return (r > 7) || (r < -8);
    endfunction

    // sum/cout may only move on a completing edge (done follows) or under reset
    always @(posedge clk) rst_at_edge <= !reset_n;
    always @(negedge clk) begin
        if (mon_en && ({cout, sum} !== prev_res))
            check("result_stable", 32'(done | rst_at_edge), 32'd1);
        prev_res <= {cout, sum};
    end

    // Starts at a negedge; returns at the negedge after the done cycle (IDLE)
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                           input int inj_at);
        int n, bc;
        logic [W:0] exp;
        exp   = (W+1)'(av) + (W+1)'(bv) + (W+1)'(ci);
        start = 1'b1; a = av; b = bv; cin = ci;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 1; bc = 0;
        while (n <= 20) begin
            if (busy) bc++;
            if (done) break;
            if (n == inj_at) begin
                start = 1'b1; a = '1; b = '1; cin = 1'b1;
            end else if (n == inj_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(W + 1));
        check("busy_cycles", 32'(bc), 32'(W + 1));
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf", 32'(ovf), 32'(ref_ovf(av, bv, ci)));
`endif
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic count_done(input int cycles, input string tag);
        int d;
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) d++;
            @(negedge clk);
        end
        check(tag, 32'(d), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        run_add(4'd0, 4'd0, 1'b0, 0);
        run_add(4'd7, 4'd9, 1'b0, 0);
        run_add(4'd15, 4'd15, 1'b1, 0);

        run_add(4'd3, 4'd4, 1'b0, 2);
        count_done(W + 3, "ignored_start_no_done");

        // abort mid-shift with reset
        start = 1'b1; a = 4'd6; b = 4'd5; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        count_done(W + 2, "abort_no_done");
        run_add(4'd6, 4'd5, 1'b0, 0);

        run_add(4'd5, 4'd3, 1'b0, 0);
        run_add(4'd8, 4'd8, 1'b0, 0);
        run_add(4'd2, 4'd3, 1'b0, 0);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_add(v[3:0], v[7:4], v[8], 0);
        end

        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_add(W'($urandom), W'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, W)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
